pipe_issue_sched: RTL
=====================

// Module: pipe_issue_sched
// PURPOSE
//  Issue scheduler for the 4-stage regbank/ALU/mem pipeline (fetch-operands, ALU, writeback, mem store).
//  Arbitrates NREQ instruction requesters round-robin onto the single pipeline issue port.
//  Tracks in-flight destination registers in a scoreboard and holds back RAW-hazarded instructions.
//  Rejects illegal func codes. Sits between the instruction sources and the pipeline's rs1/rs2/rd/func/addr inputs.
// PARAMETERS
//  NREQ    2  number of requesters (2..4)
//  WB_LAT  2  cycles from iss_valid until the regbank write of that instruction is visible (1..4)
//  SCW     16 width of the stall_cnt statistics counter
// PORTS
//  clk          in   1        single system clock; all state on posedge
//  rst_n        in   1        asynchronous, active-low reset
//  req_valid    in   NREQ     requester i has an instruction
//  req_ready    out  NREQ     one-hot grant; transfer when req_valid[i] & req_ready[i]
//  req_rs1      in   4*NREQ   source A register index, requester i in [4i+3:4i]
//  req_rs2      in   4*NREQ   source B register index
//  req_rd       in   4*NREQ   destination register index
//  req_func     in   4*NREQ   ALU function code (0..11 legal)
//  req_addr     in   8*NREQ   memory store address
//  iss_valid    out  1        instruction presented to pipeline this cycle
//  iss_rs1/iss_rs2/iss_rd/iss_func  out 4 each; iss_addr out 8   registered issue fields
//  iss_src      out  log2(NREQ) (min 1)  requester index of issued instruction
//  err_func     out  1        one-cycle pulse: illegal func consumed and dropped
//  stall_cnt    out  SCW      saturating count of hazard-stall cycles
// BEHAVIOUR
//  - Reset (async): req_ready=0, all iss_* = 0, err_func=0, stall_cnt=0, scoreboard empty, RR pointer=0.
//  - Operand use: func 0,1,2,5,6,7 read A and B; 3,8,10,11 read A only; 4,9 read B only; 12..15 illegal.
//  - Eligible(i): req_valid[i] & no scoreboard entry matching a used operand. Illegal func is always eligible.
//  - Grant: combinational; at most one bit set. Selects the first eligible requester at or after the RR pointer.
//    On any grant the pointer moves to grant index+1 (mod NREQ). Without a grant the pointer holds.
//  - Accept cycle a, legal func: iss_* loaded, iss_valid=1 in cycle a+1 only (1-cycle latency).
//    rd is pushed into the scoreboard shift register (WB_LAT entries) and is live for accept cycles a+1..a+WB_LAT.
//  - Illegal func: consumed (ready=1), err_func=1 in a+1, iss_valid=0 in a+1, nothing pushed to scoreboard.
//  - iss_valid is 0 in any cycle after a cycle without an accept; iss_* fields hold their last value.
//  - WAW/WAR never stall (in-order pipeline). rd equal to a live entry is pushed again; both entries age independently.
//  - stall_cnt +1 in each cycle where |req_valid and no grant; holds at 2^SCW-1.
//  - The scoreboard shifts every cycle regardless of grants; entries expire after WB_LAT cycles.
//  - Reset mid-operation: scoreboard and outputs are cleared immediately. In-flight pipeline results are not tracked afterwards.
//  - Requesters must hold their fields stable while req_valid=1 and ready=0. Dropping valid before the grant is legal.
// STRUCTURE
//  - Shared package pipe_pkg: FUNC_* codes (ADD=0 .. SHL=11), FUNC_MAX=11, register index width 4, address width 8,
//    and functions uses_a(func) and uses_b(func). The ALU stage uses the same package.
//  - One sub-module: pipe_scoreboard (WB_LAT-deep rd shift register; inputs push/rd, rs1/rs2/use flags; output hazard).
//    Instantiated once, queried per requester through NREQ comparator sets.
//  - Arbiter (rotate, priority-select, rotate back), issue register and stall counter stay in this top.
// TESTING
//  1 Reset: assert rst_n=0 mid-burst -> all outputs 0 within the same cycle; after release, first grant goes to req 0.
//  2 RAW stall, WB_LAT=2: req0 rd=3 accepted in cycle 0; req0 next instr rs1=3 -> accepted cycle 3, iss_valid cycle 4,
//    stall_cnt=2.
//  3 Round-robin: both requesters always valid and hazard-free -> grants alternate 0,1,0,1; iss_src matches the grant.
//  4 Hazard bypass: req0 blocked on rs2=5 (func 0), req1 independent -> req1 granted the same cycle;
//    stall_cnt does not increment that cycle.
//  5 Operand masking: producer rd=7, consumer func=4 with rs1=7, rs2=2 -> no stall, issued the next cycle.
//  6 Illegal func=13 -> ready=1, err_func pulse one cycle later, iss_valid=0, no scoreboard entry;
//    stall_cnt saturates at 16'hFFFF under a forced permanent hazard.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared ALU function codes, field widths and operand-use helpers
package pipe_pkg;

  localparam int REG_W  = 4;
  localparam int ADDR_W = 8;
  localparam int FUNC_W = 4;

  typedef enum logic [FUNC_W-1:0] {
    FUNC_ADD  = 4'd0,
    FUNC_SUB  = 4'd1,
    FUNC_AND  = 4'd2,
    FUNC_NOT  = 4'd3,
    FUNC_MOVB = 4'd4,
    FUNC_OR   = 4'd5,
    FUNC_XOR  = 4'd6,
    FUNC_SLT  = 4'd7,
    FUNC_INC  = 4'd8,
    FUNC_NEGB = 4'd9,
    FUNC_SHR  = 4'd10,
    FUNC_SHL  = 4'd11
  } func_e;

  localparam logic [FUNC_W-1:0] FUNC_MAX = FUNC_SHL;

  typedef struct packed {
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic [FUNC_W-1:0] func;
    logic [ADDR_W-1:0] addr;
  } instr_t;

  function automatic logic func_legal(input logic [FUNC_W-1:0] f);
    return f <= FUNC_MAX;
  endfunction

  function automatic logic uses_a(input logic [FUNC_W-1:0] f);
    return f inside {FUNC_ADD, FUNC_SUB, FUNC_AND, FUNC_NOT, FUNC_OR,
                     FUNC_XOR, FUNC_SLT, FUNC_INC, FUNC_SHR, FUNC_SHL};
  endfunction

  function automatic logic uses_b(input logic [FUNC_W-1:0] f);
    return f inside {FUNC_ADD, FUNC_SUB, FUNC_AND, FUNC_MOVB, FUNC_OR,
                     FUNC_XOR, FUNC_SLT, FUNC_NEGB};
  endfunction

endpackage

// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard: WB_LAT-deep shift register of in-flight destination registers with per-requester RAW checks
module pipe_scoreboard
  import pipe_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int WB_LAT = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [REG_W-1:0]           push_rd_i,
  input  logic [NREQ-1:0][REG_W-1:0] rs1_i,
  input  logic [NREQ-1:0][REG_W-1:0] rs2_i,
  input  logic [NREQ-1:0]            use_a_i,
  input  logic [NREQ-1:0]            use_b_i,
  output logic [NREQ-1:0]            hazard_o
);

  logic [WB_LAT-1:0]            vld_q;
  logic [WB_LAT-1:0][REG_W-1:0] rd_q;

  // Shift every cycle; slot k holds the rd accepted k+1 cycles ago
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      rd_q  <= '0;
    end else begin
      vld_q[0] <= push_i;
      rd_q[0]  <= push_rd_i;
      for (int k = 1; k < WB_LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
        rd_q[k]  <= rd_q[k-1];
      end
    end
  end

  // A requester is hazarded when any live entry matches an operand it actually reads
  always_comb begin
    hazard_o = '0;
    for (int i = 0; i < NREQ; i++)
      for (int k = 0; k < WB_LAT; k++)
        if (vld_q[k] && ((use_a_i[i] && rd_q[k] == rs1_i[i]) ||
                         (use_b_i[i] && rd_q[k] == rs2_i[i])))
          hazard_o[i] = 1'b1;
  end

endmodule

// File: rtl/pipe_issue_sched.sv
// pipe_issue_sched: round-robin issue arbiter with RAW scoreboard, illegal-func drop and stall statistics
module pipe_issue_sched
  import pipe_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int WB_LAT = 2,
  parameter int SCW    = 16,
  localparam int SW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NREQ-1:0]          req_valid_i,
  output logic [NREQ-1:0]          req_ready_o,
  input  logic [REG_W*NREQ-1:0]    req_rs1_i,
  input  logic [REG_W*NREQ-1:0]    req_rs2_i,
  input  logic [REG_W*NREQ-1:0]    req_rd_i,
  input  logic [FUNC_W*NREQ-1:0]   req_func_i,
  input  logic [ADDR_W*NREQ-1:0]   req_addr_i,
  output logic                     iss_valid_o,
  output logic [REG_W-1:0]         iss_rs1_o,
  output logic [REG_W-1:0]         iss_rs2_o,
  output logic [REG_W-1:0]         iss_rd_o,
  output logic [FUNC_W-1:0]        iss_func_o,
  output logic [ADDR_W-1:0]        iss_addr_o,
  output logic [SW-1:0]            iss_src_o,
  output logic                     err_func_o,
  output logic [SCW-1:0]           stall_cnt_o
);

  instr_t [NREQ-1:0]            req;
  logic   [NREQ-1:0][REG_W-1:0] rs1, rs2;
  logic   [NREQ-1:0]            use_a, use_b, legal, hazard, elig, grant;
  logic   [2*NREQ-1:0]          rot_dbl, back_dbl;
  logic   [NREQ-1:0]            rot, rot_gnt;
  logic   [SW-1:0]              sel, ptr_q, ptr_d;
  logic                         acc, push;
  instr_t                       iss_q;
  logic                         iss_valid_q, err_q;
  logic   [SW-1:0]              src_q;
  logic   [SCW-1:0]             stall_q, stall_d;

  genvar g;
  for (g = 0; g < NREQ; g++) begin : g_unpack
    assign req[g]   = '{rs1:  req_rs1_i[REG_W*g +: REG_W],
                        rs2:  req_rs2_i[REG_W*g +: REG_W],
                        rd:   req_rd_i[REG_W*g +: REG_W],
                        func: req_func_i[FUNC_W*g +: FUNC_W],
                        addr: req_addr_i[ADDR_W*g +: ADDR_W]};
    assign rs1[g]   = req[g].rs1;
    assign rs2[g]   = req[g].rs2;
    assign use_a[g] = uses_a(req[g].func);
    assign use_b[g] = uses_b(req[g].func);
    assign legal[g] = func_legal(req[g].func);
  end

  pipe_scoreboard #(.NREQ(NREQ), .WB_LAT(WB_LAT)) u_sb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push_i    (push),
    .push_rd_i (req[sel].rd),
    .rs1_i     (rs1),
    .rs2_i     (rs2),
    .use_a_i   (use_a),
    .use_b_i   (use_b),
    .hazard_o  (hazard)
  );

  // Illegal funcs bypass the hazard check so they are always drained
  assign elig = req_valid_i & (~legal | ~hazard);

  // Rotate so the RR pointer sits at bit 0, isolate the lowest set bit, rotate back
  always_comb begin
    rot_dbl  = {elig, elig} >> ptr_q;
    rot      = rot_dbl[NREQ-1:0];
    rot_gnt  = rot & (~rot + NREQ'(1));
    back_dbl = {rot_gnt, rot_gnt} << ptr_q;
    grant    = back_dbl[2*NREQ-1:NREQ];
    sel      = '0;
    for (int i = 0; i < NREQ; i++)
      if (grant[i]) sel = SW'(i);
  end

  assign acc         = |grant;
  assign push        = acc & legal[sel];
  assign ptr_d       = (sel == SW'(NREQ - 1)) ? '0 : sel + SW'(1);
  assign stall_d     = (|req_valid_i && !acc && !(&stall_q)) ? stall_q + SCW'(1) : stall_q;
  assign req_ready_o = grant & {NREQ{rst_ni}};

  // Issue register, error pulse, RR pointer and stall statistics
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      iss_q       <= '0;
      iss_valid_q <= 1'b0;
      err_q       <= 1'b0;
      src_q       <= '0;
      ptr_q       <= '0;
      stall_q     <= '0;
    end else begin
      iss_valid_q <= push;
      err_q       <= acc & ~legal[sel];
      stall_q     <= stall_d;
      if (push) begin
        iss_q <= req[sel];
        src_q <= sel;
      end
      if (acc) ptr_q <= ptr_d;
    end
  end

  assign iss_valid_o = iss_valid_q;
  assign iss_rs1_o   = iss_q.rs1;
  assign iss_rs2_o   = iss_q.rs2;
  assign iss_rd_o    = iss_q.rd;
  assign iss_func_o  = iss_q.func;
  assign iss_addr_o  = iss_q.addr;
  assign iss_src_o   = src_q;
  assign err_func_o  = err_q;
  assign stall_cnt_o = stall_q;

endmodule
